// File: rtl/reg_writeback.sv
// Writeback stage of the bexkat1 pipeline: drives the register-file write port,
// stalls upstream while a load is outstanding, counts retirements and flags load faults.
module reg_writeback #(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] ir_i,
    input  logic [31:0] pc_i,
    input  logic [1:0]  reg_write_i,
    input  logic [31:0] result_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_dat_i,
    input  logic        mem_err_i,
    output logic        stall_o,
    output logic [1:0]  reg_write_o,
    output logic [3:0]  reg_write_addr_o,
    output logic [31:0] reg_data_o,
    output logic [31:0] retired_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    localparam logic [3:0] T_LOAD = 4'd7;
    localparam logic [7:0] TIMER_LAST = 8'(LOAD_TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t      state;
    logic [7:0]  timer;
    logic [3:0]  ld_op;
    logic [3:0]  ld_addr;
    logic [1:0]  ld_we;
    logic [31:0] ld_pc;

    logic        bubble;
    logic        is_load;
    logic        timeout;
    logic [1:0]  size;
    logic [31:0] load_data;

    assign bubble  = (ir_i == '0);
    assign is_load = (ir_i[31:28] == T_LOAD) && (reg_write_i != '0);
    assign timeout = (timer == TIMER_LAST);

    // While waiting, the access size comes from the captured instruction, not ir_i.
    always_comb begin
        size = (state == WAIT_LOAD) ? ld_op[1:0] : ir_i[25:24];
        case (size)
            2'b01:   load_data = {16'h0, mem_dat_i[15:0]};
            2'b10:   load_data = {24'h0, mem_dat_i[7:0]};
            default: load_data = mem_dat_i;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        if (state == IDLE)
            stall_o = !bubble && is_load && !mem_err_i && !mem_ack_i;
        else
            stall_o = !mem_err_i && !mem_ack_i && !timeout;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            timer            <= '0;
            ld_op            <= '0;
            ld_addr          <= '0;
            ld_we            <= '0;
            ld_pc            <= '0;
            reg_write_o      <= '0;
            reg_write_addr_o <= '0;
            reg_data_o       <= '0;
            retired_o        <= '0;
            fault_o          <= 1'b0;
            fault_pc_o       <= '0;
        end else begin
            reg_write_o <= '0;
            fault_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bubble) begin
                        if (is_load) begin
                            if (mem_err_i) begin
                                fault_o    <= 1'b1;
                                fault_pc_o <= pc_i;
                            end else if (mem_ack_i) begin
                                reg_write_o      <= reg_write_i;
                                reg_write_addr_o <= ir_i[23:20];
                                reg_data_o       <= load_data;
                                retired_o        <= retired_o + 32'd1;
                            end else begin
                                ld_op   <= ir_i[27:24];
                                ld_addr <= ir_i[23:20];
                                ld_we   <= reg_write_i;
                                ld_pc   <= pc_i;
                                timer   <= '0;
                                state   <= WAIT_LOAD;
                            end
                        end else begin
                            reg_write_o      <= reg_write_i;
                            reg_write_addr_o <= ir_i[23:20];
                            reg_data_o       <= result_i;
                            retired_o        <= retired_o + 32'd1;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (mem_err_i || (!mem_ack_i && timeout)) begin
                        fault_o    <= 1'b1;
                        fault_pc_o <= ld_pc;
                        state      <= IDLE;
                    end else if (mem_ack_i) begin
                        reg_write_o      <= ld_we;
                        reg_write_addr_o <= ld_addr;
                        reg_data_o       <= load_data;
                        retired_o        <= retired_o + 32'd1;
                        state            <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: stimulus pushes expected commits/faults into a
// queue; a negedge monitor pops and compares whenever a write or fault appears.
module tb_reg_writeback;

    localparam logic [3:0] T_ALU  = 4'd2;
    localparam logic [3:0] T_LOAD = 4'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ir;
    logic [31:0] pc;
    logic [1:0]  we_in;
    logic [31:0] res;
    logic        ack;
    logic [31:0] dat;
    logic        err;
    logic        stall;
    logic [1:0]  we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] retired;
    logic        fault;
    logic [31:0] fpc;

    reg_writeback #(.LOAD_TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst), .ir_i(ir), .pc_i(pc), .reg_write_i(we_in),
        .result_i(res), .mem_ack_i(ack), .mem_dat_i(dat), .mem_err_i(err),
        .stall_o(stall), .reg_write_o(we), .reg_write_addr_o(waddr),
        .reg_data_o(wdata), .retired_o(retired), .fault_o(fault), .fault_pc_o(fpc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          flt;
        logic [1:0]  we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] fpc;
        logic [31:0] ret;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_ret    = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: any write pulse or fault pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (we != 2'b00 || fault)) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_output: got we=%b fault=%b expected no output", we, fault);
            end else begin
                mon_e = q.pop_front();
                chk("latency_cycle", cyc, mon_e.cyc);
                chk("fault_flag", {31'h0, fault}, {31'h0, mon_e.flt});
                chk("retired", retired, mon_e.ret);
                if (mon_e.flt) begin
                    chk("fault_we", {30'h0, we}, 32'h0);
                    chk("fault_pc", fpc, mon_e.fpc);
                end else begin
                    chk("we", {30'h0, we}, {30'h0, mon_e.we});
                    chk("addr", {28'h0, waddr}, {28'h0, mon_e.addr});
                    chk("data", wdata, mon_e.data);
                end
            end
        end
    end

    function automatic logic [63:0] mk(logic [3:0] t, logic [3:0] op, logic [3:0] ra);
        return {32'h0, t, op, ra, 20'h0};
    endfunction

    task automatic idle_in();
        ir = '0; pc = '0; we_in = '0; res = '0; ack = 1'b0; dat = '0; err = 1'b0;
    endtask

    task automatic push_wr(logic [1:0] w, logic [3:0] a, logic [31:0] d);
        exp_ret = exp_ret + 32'd1;
        q.push_back('{cyc + 1, 1'b0, w, a, d, 32'h0, exp_ret});
    endtask

    task automatic push_flt(logic [31:0] p);
        q.push_back('{cyc + 1, 1'b1, 2'b00, 4'h0, 32'h0, p, exp_ret});
    endtask

    task automatic step(logic exp_stall, string nm);
        @(negedge clk);
        chk(nm, {31'h0, stall}, {31'h0, exp_stall});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_we", {30'h0, we}, 32'h0);
        chk("rst_addr", {28'h0, waddr}, 32'h0);
        chk("rst_data", wdata, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_fault_pc", fpc, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1;

        // ALU pass-through
        ir = mk(T_ALU, 4'h0, 4'd5); pc = 32'h4; we_in = 2'd3; res = 32'hDEADBEEF;
        push_wr(2'd3, 4'd5, 32'hDEADBEEF);
        step(1'b0, "alu_stall");

        // Bubble with a stray ack: nothing happens
        idle_in(); ack = 1'b1; dat = 32'hFFFF_FFFF;
        step(1'b0, "bubble_stall");

        // Load, same-cycle ack, byte
        idle_in();
        ir = mk(T_LOAD, 4'd2, 4'd7); pc = 32'h8; we_in = 2'd3; ack = 1'b1; dat = 32'h12345678;
        push_wr(2'd3, 4'd7, 32'h00000078);
        step(1'b0, "ld_ack_stall");

        // Load, ack three cycles late, halfword; ir_i held as upstream would
        idle_in();
        ir = mk(T_LOAD, 4'd1, 4'd2); pc = 32'h200; we_in = 2'd1; res = 32'h0BAD0BAD;
        step(1'b1, "ld3_stall0");
        step(1'b1, "ld3_stall1");
        step(1'b1, "ld3_stall2");
        ack = 1'b1; dat = 32'hAAAA5555;
        push_wr(2'd1, 4'd2, 32'h00005555);
        step(1'b0, "ld3_ack_stall");
        idle_in();
        step(1'b0, "gap_stall");

        // Load error on second wait cycle
        ir = mk(T_LOAD, 4'd0, 4'd9); pc = 32'h100; we_in = 2'd3;
        step(1'b1, "err_stall0");
        step(1'b1, "err_stall1");
        err = 1'b1;
        push_flt(32'h100);
        step(1'b0, "err_stall_drop");
        idle_in();

        // Simultaneous ack and error in the issue cycle: error wins
        ir = mk(T_LOAD, 4'd0, 4'd4); pc = 32'h180; we_in = 2'd3;
        ack = 1'b1; err = 1'b1; dat = 32'h55555555;
        push_flt(32'h180);
        step(1'b0, "ackerr_stall");
        idle_in();

        // Timeout with LOAD_TIMEOUT=4
        ir = mk(T_LOAD, 4'd0, 4'd6); pc = 32'h300; we_in = 2'd3;
        step(1'b1, "to_stall0");
        step(1'b1, "to_stall1");
        step(1'b1, "to_stall2");
        step(1'b1, "to_stall3");
        push_flt(32'h300);
        step(1'b0, "to_stall_drop");
        idle_in();

        // Back in IDLE: single-cycle ALU commit
        ir = mk(T_ALU, 4'h0, 4'd3); pc = 32'h304; we_in = 2'd2; res = 32'hCAFEF00D;
        push_wr(2'd2, 4'd3, 32'hCAFEF00D);
        step(1'b0, "post_to_alu_stall");
        idle_in();
        step(1'b0, "gap2_stall");

        // Reset while waiting, then a stray ack
        ir = mk(T_LOAD, 4'd0, 4'd8); pc = 32'h400; we_in = 2'd3;
        step(1'b1, "rw_stall0");
        step(1'b1, "rw_stall1");
        rst = 1'b1;
        idle_in();
        exp_ret = '0;
        @(negedge clk);
        chk("midrst_we", {30'h0, we}, 32'h0);
        chk("midrst_retired", retired, 32'h0);
        chk("midrst_fault", {31'h0, fault}, 32'h0);
        chk("midrst_stall", {31'h0, stall}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        ack = 1'b1; dat = 32'h12345678;
        step(1'b0, "stray_ack_stall");
        idle_in();
        step(1'b0, "post_stray_stall");
        chk("post_rst_fault_pc", fpc, 32'h0);

        ir = mk(T_ALU, 4'h0, 4'd1); pc = 32'h500; we_in = 2'd1; res = 32'h00000042;
        push_wr(2'd1, 4'd1, 32'h00000042);
        step(1'b0, "final_alu_stall");
        idle_in();
        repeat (3) step(1'b0, "drain_stall");

        chk("queue_drained", q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
